// File: rtl/alu_req_dispatch.sv
// ALU request FIFO. The head request is steered to one of NUM_LANES lanes by its warp id.
// Define ALU_REQ_BYPASS_EN for a same-cycle path when empty and for accepting a push while full if the head pops.
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef INST_ALU_BITS
`define INST_ALU_BITS 4
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef NT_BITS
`define NT_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module alu_req_dispatch #(
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned DATAW     = `UUID_BITS + `NW_BITS + `NUM_THREADS + 64 + `INST_ALU_BITS
                                    + `INST_MOD_BITS + 34 + `NT_BITS + 64*`NUM_THREADS + `NR_BITS + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic [DATAW-1:0]            in_data,
   output logic                        in_ready,
   input  logic                        flush_valid,
   input  logic [`NW_BITS-1:0]         flush_wid,
   output logic [NUM_LANES-1:0]        out_valid,
   output logic [NUM_LANES*DATAW-1:0]  out_data,
   input  logic [NUM_LANES-1:0]        out_ready,
   output logic [$clog2(DEPTH):0]      occupancy,
   output logic                        empty
);
   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned WID_LSB   = DATAW - `UUID_BITS - `NW_BITS;

   logic [DATAW-1:0]     mem [DEPTH];
   logic [DEPTH-1:0]     kill;
   logic [DEPTH-1:0]     live_mask;
   logic [AW:0]          wptr, rptr;
   logic [AW-1:0]        widx, ridx;
   logic                 full, head_live, pop, push, in_kill, bypass;
   logic [DATAW-1:0]     head;
   logic [LANE_BITS-1:0] head_lane;

   function automatic logic [LANE_BITS-1:0] lane_of(input logic [DATAW-1:0] d);
      if (NUM_LANES == 1) return '0;
      return d[WID_LSB +: LANE_BITS];
   endfunction

   assign widx      = wptr[AW-1:0];
   assign ridx      = rptr[AW-1:0];
   assign empty     = (wptr == rptr);
   assign full      = (wptr == {~rptr[AW], rptr[AW-1:0]});
   assign occupancy = wptr - rptr;
   assign head      = mem[ridx];
   assign head_lane = lane_of(head);
   assign head_live = !empty && !kill[ridx];
   // A killed head leaves in one cycle whatever its lane's out_ready is.
   assign pop       = !empty && (kill[ridx] || out_ready[head_lane]);
   assign in_kill   = flush_valid && (in_data[WID_LSB +: `NW_BITS] == flush_wid);

`ifdef ALU_REQ_BYPASS_EN
   logic [LANE_BITS-1:0] in_lane;
   assign in_lane  = lane_of(in_data);
   assign bypass   = empty && in_valid && out_ready[in_lane];
   assign in_ready = !full || pop;
`else
   assign bypass   = 1'b0;
   assign in_ready = !full;
`endif
   assign push = in_valid && in_ready && !bypass;

   always_comb begin
      out_valid = '0;
      out_data  = {NUM_LANES{head}};
      if (head_live) out_valid[head_lane] = 1'b1;
`ifdef ALU_REQ_BYPASS_EN
      // A flushed bypass request is swallowed: accepted upstream, never presented.
      if (bypass) begin
         out_data           = {NUM_LANES{in_data}};
         out_valid[in_lane] = !in_kill;
      end
`endif
   end

   always_comb begin
      live_mask = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         live_mask[i] = ({1'b0, AW'(AW'(i) - ridx)} < occupancy);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         kill <= '0;
      end else begin
         if (flush_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (live_mask[i] && (mem[i][WID_LSB +: `NW_BITS] == flush_wid)) kill[i] <= 1'b1;
            end
         end
         // Placed after the flush loop so a push into the slot being vacated owns its kill bit.
         if (push) begin
            kill[widx] <= in_kill;
            wptr       <= wptr + 1'b1;
         end
         if (pop) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[widx] <= in_data;
   end

endmodule

// File: doc/alu_req_dispatch.md
Name: alu_req_dispatch

Overview:
- Parametrised successor to the single-channel ALU request bundle.
- Buffers ALU requests from issue in a DEPTH-entry FIFO and steers each one to one of NUM_LANES ALU lanes, selected by warp id.
- Supports per-warp flush of queued requests and reports occupancy.
- Sits between the issue stage and the ALU lane array.

Parameters:
- NUM_LANES, 2: ALU lane count; power of 2, 1..8. LANE_BITS = max(1, log2(NUM_LANES)).
- DEPTH, 4: FIFO entries; power of 2, 2..16.
- DATAW, derived: `UUID_BITS + `NW_BITS + `NUM_THREADS + 64 + `INST_ALU_BITS + `INST_MOD_BITS + 34 + `NT_BITS + 64*`NUM_THREADS + `NR_BITS + 1.
  - Field packing, MSB to LSB: uuid, wid, tmask, PC, next_PC, op_type, op_mod, use_PC, use_imm, imm, tid, rs1_data, rs2_data, rd, wb.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_data  in  DATAW  packed request payload
- in_ready  out  1  request accepted when in_valid && in_ready
- flush_valid  in  1  kill queued requests of one warp
- flush_wid  in  `NW_BITS  warp to kill
- out_valid  out  NUM_LANES  per-lane request valid
- out_data  out  NUM_LANES*DATAW  per-lane payload; lane k occupies slice k
- out_ready  in  NUM_LANES  per-lane accept
- occupancy  out  log2(DEPTH)+1  live FIFO entries, including killed entries not yet drained
- empty  out  1  occupancy == 0

Behaviour:
- Reset (reset low, asynchronous): FIFO pointers = 0, occupancy = 0, empty = 1, in_ready = 1, out_valid = 0, all entry kill bits = 0. Payload storage is not reset.
- Entry state: each entry holds the payload plus a kill bit. Write and read pointers are log2(DEPTH)+1 bits with wrap bit. Full when the pointers differ only in the MSB.
- in_ready = !full. Dependence on out_ready is permitted only when ALU_REQ_BYPASS_EN is set.
- Push: on in_valid && in_ready, write the entry with kill = 0 and advance wptr.
- Target lane = head wid[LANE_BITS-1:0]; NUM_LANES = 1 gives lane 0.
- Dispatch:
  - Only the head entry is considered; head-of-line blocking is intended and keeps per-warp order.
  - out_valid[lane] = !empty && !head.kill. All other out_valid bits = 0.
  - out_data is driven to the head payload on every lane; only the valid lane matters.
- Pop occurs when:
  - the head is not killed and out_valid[lane] && out_ready[lane], or
  - the head is killed; a killed head is dropped in one cycle with no output.
- Latency: a request pushed in cycle t is visible on out_valid in cycle t+1 at the earliest (no bypass).
- Flush: on flush_valid, every valid entry whose wid == flush_wid gets kill = 1 at the next edge.
  - A request being pushed in the same cycle with wid == flush_wid is also killed.
  - A head being popped in that same cycle is unaffected (the handshake already completed).
- Occupancy: push and pop in the same cycle leave it unchanged. Full with a simultaneous pop still accepts a push only when ALU_REQ_BYPASS_EN is set; otherwise in_ready = 0 whenever full.
- Wrap-around: pointers wrap modulo 2*DEPTH, with no special-casing.
- out_valid, once asserted for a head, stays asserted with stable out_data until handshake, flush kill, or reset.
- A reset asserted mid-operation discards all contents immediately.

Optional Feature:
- ALU_REQ_BYPASS_EN defined:
  - When empty, in_valid, and out_ready of the target lane of in_data are all true, the request is presented on out_valid/out_data in the same cycle and is not written to the FIFO.
  - A bypassed request whose wid == flush_wid with flush_valid is not presented; it is dropped and counted as accepted.
  - When full, in_ready = the head pop condition.
- Undefined: no combinational in-to-out path. Minimum latency is 1 cycle and in_ready = !full.

Test Plan:
- Reset with DEPTH = 4, NUM_LANES = 2 -> in_ready = 1, empty = 1, out_valid = 2'b00, occupancy = 0; reset asserted while 3 entries are held -> all cleared asynchronously.
- Push wid = 3, then wid = 2, with out_ready = 2'b11 -> cycle t+1 out_valid = 2'b10 (wid 3); cycle t+2 out_valid = 2'b01 (wid 2); order preserved.
- Push 4 requests with out_ready = 0 -> occupancy = 4, in_ready = 0; release out_ready -> one pop per cycle; 10 pushes total exercise pointer wrap, with no loss or duplication.
- Queue wid = 1, 2, 1; pulse flush_valid with flush_wid = 1 -> only wid 2 emerges; killed entries drop one per cycle; occupancy returns to 0.
- Head for lane 0 with out_ready = 2'b10 -> out_valid[0] held with stable out_data; a later entry for lane 1 stays blocked until out_ready[0] = 1.
- With ALU_REQ_BYPASS_EN, empty queue, push wid = 0 with out_ready[0] = 1 -> out_valid[0] = 1 in the same cycle and occupancy stays 0; without the macro -> out_valid[0] = 1 one cycle later.
